// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared float format constants, converter FSM states and float class codes
package fpu_pkg;

  localparam int FP_WIDTH     = 32;
  localparam int FP_EXP_WIDTH = 8;
  localparam int FP_MAN_WIDTH = 23;
  localparam int FP_BIAS      = 127;
  localparam int FP_INT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    FC_ZERO,
    FC_NORMAL,
    FC_INF,
    FC_NAN
  } float_class_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational float field split and class decode (denormals classed as zero)
module fp_unpack
  import fpu_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int EXP_WIDTH = FP_EXP_WIDTH,
  parameter int MAN_WIDTH = FP_MAN_WIDTH
) (
  input  logic [WIDTH-1:0]     word,
  output logic                 sign,
  output logic [EXP_WIDTH-1:0] exp,
  output logic [MAN_WIDTH-1:0] man,
  output float_class_t         cls
);

  always_comb begin
    sign = word[WIDTH-1];
    exp  = word[WIDTH-2 -: EXP_WIDTH];
    man  = word[MAN_WIDTH-1:0];
    cls  = FC_NORMAL;
    if (&exp) begin
      cls = (man == '0) ? FC_INF : FC_NAN;
    end else if (exp == '0) begin
      cls = FC_ZERO;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - iterative float to signed integer converter, one shift bit per cycle
// Optional round-to-nearest-even enabled by FP2INT_ROUND_EN; truncates toward zero otherwise.
module fp_to_int
  import fpu_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int EXP_WIDTH = FP_EXP_WIDTH,
  parameter int MAN_WIDTH = FP_MAN_WIDTH,
  parameter int BIAS      = FP_BIAS,
  parameter int INT_WIDTH = FP_INT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] out_data,
  output logic                 overflow,
  output logic                 invalid
);

  localparam int E_W   = EXP_WIDTH + 2;
  localparam int CNT_W = $clog2(INT_WIDTH + MAN_WIDTH + 2);

  localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(INT_WIDTH - 1);
  localparam logic signed [E_W-1:0] E_MAN  = E_W'(MAN_WIDTH);

  localparam logic [INT_WIDTH-1:0] MAX_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] MIN_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic                 u_sign;
  logic [EXP_WIDTH-1:0] u_exp;
  logic [MAN_WIDTH-1:0] u_man;
  float_class_t         u_cls;

  logic signed [E_W-1:0] e_s;
  logic [INT_WIDTH-1:0]  cap_acc;
  logic [CNT_W-1:0]      cap_count;
  logic                  cap_fixed, cap_left, cap_ovf, cap_inv;

  logic                 sign_q, left_q, fixed_q, ovf_q, inv_q;
  logic [CNT_W-1:0]     count_q;
  logic [INT_WIDTH-1:0] acc_q;
  logic [INT_WIDTH-1:0] mag;
  logic [INT_WIDTH-1:0] result;

`ifdef FP2INT_ROUND_EN
  logic guard_q, sticky_q;
`endif

  fp_unpack #(
    .WIDTH     (WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_unpack (
    .word (in_data),
    .sign (u_sign),
    .exp  (u_exp),
    .man  (u_man),
    .cls  (u_cls)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT:  if (count_q == '0) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_HOLD;
      ST_HOLD:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Class decision at capture; "fixed" results bypass rounding and negation in FINISH.
  always_comb begin
    e_s       = $signed({2'b00, u_exp}) - BIAS_S;
    cap_acc   = '0;
    cap_count = '0;
    cap_fixed = 1'b1;
    cap_left  = 1'b0;
    cap_ovf   = 1'b0;
    cap_inv   = 1'b0;
    if (u_cls == FC_NAN || u_cls == FC_INF) begin
      cap_inv = 1'b1;
      cap_acc = (u_cls == FC_NAN || !u_sign) ? MAX_POS : MIN_NEG;
    end else if (u_cls == FC_ZERO || u_exp < EXP_WIDTH'(BIAS - 1)) begin
      cap_acc = '0;
    end else if (e_s >= E_MAX) begin
      if (u_sign && e_s == E_MAX && u_man == '0) begin
        cap_acc = MIN_NEG;
      end else begin
        cap_ovf = 1'b1;
        cap_acc = u_sign ? MIN_NEG : MAX_POS;
      end
    end else begin
      cap_fixed = 1'b0;
      cap_acc   = INT_WIDTH'({1'b1, u_man});
      if (e_s >= E_MAN) begin
        cap_left  = 1'b1;
        cap_count = CNT_W'(e_s - E_MAN);
      end else begin
        cap_count = CNT_W'(E_MAN - e_s);
      end
    end
  end

  always_comb begin
`ifdef FP2INT_ROUND_EN
    mag = acc_q + INT_WIDTH'(guard_q & (sticky_q | acc_q[0]));
`else
    mag = acc_q;
`endif
    result = fixed_q ? acc_q : (sign_q ? -mag : mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      fixed_q  <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
`ifdef FP2INT_ROUND_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q   <= u_sign;
            left_q   <= cap_left;
            fixed_q  <= cap_fixed;
            ovf_q    <= cap_ovf;
            inv_q    <= cap_inv;
            count_q  <= cap_count;
            acc_q    <= cap_acc;
`ifdef FP2INT_ROUND_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (count_q != '0) begin
            count_q <= count_q - 1'b1;
            if (left_q) begin
              acc_q <= acc_q << 1;
            end else begin
              acc_q <= acc_q >> 1;
`ifdef FP2INT_ROUND_EN
              guard_q  <= acc_q[0];
              sticky_q <= sticky_q | guard_q;
`endif
            end
          end
        end
        ST_FINISH: begin
          out_data <= result;
          overflow <= ovf_q;
          invalid  <= inv_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// tb/tb_fp_to_int.sv - directed self-checking bench for fp_to_int (honours FP2INT_ROUND_EN)
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        overflow;
  logic        invalid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FP2INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  fp_to_int dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  // Drives one operand and waits for the result; optionally leaves it un-acknowledged.
  task automatic run_op(input logic [31:0] f, input bit ack,
                        output logic [31:0] d, output logic ov, output logic iv, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    in_data  = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL timeout in=%08h no out_valid after %0d cycles", f, lat);
    end
    d  = out_data;
    ov = overflow;
    iv = invalid;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    n_checks += 5;
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 32'h0)  begin n_fail++; $display("FAIL reset_out_data got %08h want 0", out_data); end
    if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (invalid !== 1'b0)    begin n_fail++; $display("FAIL reset_invalid got %b want 0", invalid); end
  endtask

  // Value, flags and latency for a table of normal/boundary operands.
  task automatic test_convert;
    logic [31:0] vin  [8];
    logic [31:0] vexp [8];
    logic        vov  [8];
    logic        viv  [8];
    int          vlat [8];
    logic [31:0] d;
    logic        ov, iv;
    int          lat;
    vin[0] = 32'h3F800000; vexp[0] = 32'd1;          vov[0] = 0; viv[0] = 0; vlat[0] = 25;
    vin[1] = 32'h40600000; vexp[1] = RND ? 32'd4 : 32'd3; vov[1] = 0; viv[1] = 0; vlat[1] = 24;
    vin[2] = 32'hC0200000; vexp[2] = 32'hFFFFFFFE;   vov[2] = 0; viv[2] = 0; vlat[2] = 24;
    vin[3] = 32'h3F400000; vexp[3] = RND ? 32'd1 : 32'd0; vov[3] = 0; viv[3] = 0; vlat[3] = 26;
    vin[4] = 32'h4B800000; vexp[4] = 32'h01000000;   vov[4] = 0; viv[4] = 0; vlat[4] = 3;
    vin[5] = 32'h4EFFFFFF; vexp[5] = 32'h7FFFFF80;   vov[5] = 0; viv[5] = 0; vlat[5] = 9;
    vin[6] = 32'h4F000000; vexp[6] = 32'h7FFFFFFF;   vov[6] = 1; viv[6] = 0; vlat[6] = 2;
    vin[7] = 32'hCF000000; vexp[7] = 32'h80000000;   vov[7] = 0; viv[7] = 0; vlat[7] = 2;
    for (int i = 0; i < 8; i++) begin
      run_op(vin[i], 1'b1, d, ov, iv, lat);
      n_checks += 3;
      if (d !== vexp[i]) begin n_fail++; $display("FAIL conv_data in=%08h got %08h want %08h", vin[i], d, vexp[i]); end
      if ({ov, iv} !== {vov[i], viv[i]}) begin
        n_fail++; $display("FAIL conv_flags in=%08h got ov=%b iv=%b want ov=%b iv=%b", vin[i], ov, iv, vov[i], viv[i]);
      end
      if (lat != vlat[i]) begin n_fail++; $display("FAIL conv_latency in=%08h got %0d want %0d", vin[i], lat, vlat[i]); end
    end
  endtask

  task automatic test_specials;
    logic [31:0] vin  [5];
    logic [31:0] vexp [5];
    logic        viv  [5];
    logic [31:0] d;
    logic        ov, iv;
    int          lat;
    vin[0] = 32'h7FC00000; vexp[0] = 32'h7FFFFFFF; viv[0] = 1;
    vin[1] = 32'hFF800000; vexp[1] = 32'h80000000; viv[1] = 1;
    vin[2] = 32'h00000001; vexp[2] = 32'h0;        viv[2] = 0;
    vin[3] = 32'h3E800000; vexp[3] = 32'h0;        viv[3] = 0;
    vin[4] = 32'h7F800000; vexp[4] = 32'h7FFFFFFF; viv[4] = 1;
    for (int i = 0; i < 5; i++) begin
      run_op(vin[i], 1'b1, d, ov, iv, lat);
      n_checks += 3;
      if (d !== vexp[i]) begin n_fail++; $display("FAIL special_data in=%08h got %08h want %08h", vin[i], d, vexp[i]); end
      if ({ov, iv} !== {1'b0, viv[i]}) begin
        n_fail++; $display("FAIL special_flags in=%08h got ov=%b iv=%b want ov=0 iv=%b", vin[i], ov, iv, viv[i]);
      end
      if (lat != 2) begin n_fail++; $display("FAIL special_latency in=%08h got %0d want 2", vin[i], lat); end
    end
  endtask

  task automatic test_hold;
    logic [31:0] d;
    logic        ov, iv;
    int          lat;
    run_op(32'hC0600000, 1'b0, d, ov, iv, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== (RND ? 32'hFFFFFFFC : 32'hFFFFFFFD)
          || overflow !== 1'b0 || invalid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cycle %0d got v=%b r=%b d=%08h ov=%b iv=%b want v=1 r=0 d=%08h flags 0",
                 i, out_valid, in_ready, out_data, overflow, invalid, RND ? 32'hFFFFFFFC : 32'hFFFFFFFD);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    logic        ov, iv;
    int          lat;
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_async got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    #3 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_abort got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    run_op(32'h40600000, 1'b1, d, ov, iv, lat);
    n_checks++;
    if (d !== (RND ? 32'd4 : 32'd3)) begin
      n_fail++; $display("FAIL midreset_next got %08h want %08h", d, RND ? 32'd4 : 32'd3);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_convert();
    test_specials();
    test_hold();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
